// File: rtl/game_pkg.sv
// game_pkg: shared constants for the falling-shape game.
// Board geometry (16 columns x 32 rows), VGA colour codes, the scheduler
// FSM state encodings and a colour helper.
package game_pkg;

    localparam int unsigned COLS = 16;
    localparam int unsigned ROWS = 32;
    localparam int unsigned X_W  = $clog2(COLS);
    localparam int unsigned Y_W  = $clog2(ROWS);

    localparam logic [2:0] COLOUR_ON  = 3'b111;
    localparam logic [2:0] COLOUR_OFF = 3'b000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPAWN  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_SCAN   = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    function automatic logic [2:0] pixel_colour(input logic on);
        return on ? COLOUR_ON : COLOUR_OFF;
    endfunction

endpackage

// File: rtl/game_step_sequencer_if.sv
// game_step_sequencer_if: display read port plus VGA adapter write port.
//   pixel_in     display bit at {x_rd,y_rd}, one cycle after the address
//   x_rd, y_rd   display read address
//   x, y         VGA pixel address, aligned with colour/plot
//   colour       VGA colour
//   plot         VGA write strobe
// master = sequencer side, slave = display/VGA side.
interface game_step_sequencer_if;
    import game_pkg::*;

    logic             pixel_in;
    logic [X_W-1:0]   x_rd;
    logic [Y_W-1:0]   y_rd;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [2:0]       colour;
    logic             plot;

    modport master (
        input  pixel_in,
        output x_rd, y_rd, x, y, colour, plot
    );

    modport slave (
        output pixel_in,
        input  x_rd, y_rd, x, y, colour, plot
    );

endinterface

// File: rtl/tick_divider.sv
// tick_divider: counts 0..PERIOD-1 while en=1 and holds while en=0.
// tick is high for the single cycle in which the counter wraps.
//   clock, reset  system clock, synchronous active-high reset
//   en            count enable
//   tick          wrap pulse
module tick_divider #(
    parameter int unsigned PERIOD = 833334
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_step_sequencer.sv
// game_step_sequencer: frame/step scheduler for the 16x32 game.
// Each consumed frame tick either advances the game (optional spawn, then
// shift) or only rescans; after the display settles, all 512 pixels are
// streamed to the VGA adapter one per cycle, column-major (y inner).
//   clock, reset  system clock, synchronous active-high reset
//   run           1 = game advances, 0 = pause (in IDLE only)
//   disp          display read / VGA write port (master side)
//   shift_en      1-cycle pulse: shift board down one row
//   spawn_en      1-cycle pulse: load new shape
//   scan_busy     high while scanning
//   overrun       sticky: tick arrived while a previous tick was still pending
// SETTLE_CYCLES must be at least 1.
module game_step_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_PER_FRAME   = 833334,
    parameter int unsigned FRAMES_PER_STEP = 16,
    parameter int unsigned STEPS_PER_SPAWN = 16,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    game_step_sequencer_if.master disp,
    output logic                  shift_en,
    output logic                  spawn_en,
    output logic                  scan_busy,
    output logic                  overrun
);

    localparam int unsigned FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned SC_W = (STEPS_PER_SPAWN > 1) ? $clog2(STEPS_PER_SPAWN) : 1;
    localparam int unsigned TC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [FC_W-1:0] FRAME_LAST  = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [SC_W-1:0] STEP_LAST   = SC_W'(STEPS_PER_SPAWN - 1);
    localparam logic [TC_W-1:0] SETTLE_LAST = TC_W'(SETTLE_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SC_W-1:0] step_cnt_q, step_cnt_d;
    logic            spawned_q, spawned_d;
    logic [TC_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [X_W-1:0]  x_rd_q, x_rd_d;
    logic [Y_W-1:0]  y_rd_q, y_rd_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            plot_q, plot_d;
    logic            tick;
    logic            consume;

    tick_divider #(
        .PERIOD (CLK_PER_FRAME)
    ) u_frame_div (
        .clock (clock),
        .reset (reset),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        step_cnt_d   = step_cnt_q;
        spawned_d    = spawned_q;
        settle_cnt_d = settle_cnt_q;
        x_rd_d       = x_rd_q;
        y_rd_d       = y_rd_q;
        consume      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run && pending_q) begin
                    consume = 1'b1;
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = (step_cnt_q == STEP_LAST) ? ST_SPAWN : ST_SHIFT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                        state_d     = ST_SETTLE;
                    end
                end
            end
            ST_SPAWN: begin
                step_cnt_d = '0;
                spawned_d  = 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                // the shift that follows a spawn must not undo the clear
                if (!spawned_q) step_cnt_d = step_cnt_q + SC_W'(1);
                spawned_d = 1'b0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    x_rd_d       = '0;
                    y_rd_d       = '0;
                    state_d      = ST_SCAN;
                end else begin
                    settle_cnt_d = settle_cnt_q + TC_W'(1);
                end
            end
            ST_SCAN: begin
                // addresses wrap back to {0,0} after the last pixel
                y_rd_d = y_rd_q + Y_W'(1);
                if (y_rd_q == '1) x_rd_d = x_rd_q + X_W'(1);
                if (x_rd_q == '1 && y_rd_q == '1) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // a tick landing on the consuming cycle re-arms pending without overrun
        if (tick) begin
            pending_d = 1'b1;
            if (pending_q && !consume) overrun_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end

        x_d    = x_rd_q;
        y_d    = y_rd_q;
        plot_d = (state_q == ST_SCAN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
            step_cnt_q   <= '0;
            spawned_q    <= 1'b0;
            settle_cnt_q <= '0;
            x_rd_q       <= '0;
            y_rd_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
            step_cnt_q   <= step_cnt_d;
            spawned_q    <= spawned_d;
            settle_cnt_q <= settle_cnt_d;
            x_rd_q       <= x_rd_d;
            y_rd_q       <= y_rd_d;
            x_q          <= x_d;
            y_q          <= y_d;
            plot_q       <= plot_d;
        end
    end

    assign disp.x_rd = x_rd_q;
    assign disp.y_rd = y_rd_q;
    assign disp.x    = x_q;
    assign disp.y    = y_q;
    assign disp.plot = plot_q;
    // pixel_in already lags its address by one cycle, so it lines up with the
    // registered x/y/plot without another flop; gating keeps colour 0 off-scan
    assign disp.colour = pixel_colour(plot_q & disp.pixel_in);

    assign shift_en  = (state_q == ST_SHIFT);
    assign spawn_en  = (state_q == ST_SPAWN);
    assign scan_busy = (state_q == ST_SCAN);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_game_step_sequencer.sv
module tb_game_step_sequencer;
    import game_pkg::*;

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
        logic [2:0] colour;
    } pix_t;

    localparam int EV_SHIFT             = 1;
    localparam int EV_SPAWN             = 2;
    localparam int EV_SHIFT_AFTER_SPAWN = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic run   = 1'b0;
    always #5 clock = ~clock;

    game_step_sequencer_if ifa();
    game_step_sequencer_if ifb();
    logic shift_a, spawn_a, busy_a, ovr_a;
    logic shift_b, spawn_b, busy_b, ovr_b;

    game_step_sequencer #(
        .CLK_PER_FRAME   (8),
        .FRAMES_PER_STEP (2),
        .STEPS_PER_SPAWN (3),
        .SETTLE_CYCLES   (2)
    ) dut_a (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .disp      (ifa),
        .shift_en  (shift_a),
        .spawn_en  (spawn_a),
        .scan_busy (busy_a),
        .overrun   (ovr_a)
    );

    game_step_sequencer #(
        .CLK_PER_FRAME   (100),
        .FRAMES_PER_STEP (2),
        .STEPS_PER_SPAWN (3),
        .SETTLE_CYCLES   (2)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .disp      (ifb),
        .shift_en  (shift_b),
        .spawn_en  (spawn_b),
        .scan_busy (busy_b),
        .overrun   (ovr_b)
    );

    // display model: registered read, single lit pixel at x=5,y=7 (index 32*5+7)
    logic [511:0] display;
    logic [8:0]   rd_addr_a = '0;
    initial begin
        display      = '0;
        display[167] = 1'b1;
    end
    always @(posedge clock) rd_addr_a <= {ifa.x_rd, ifa.y_rd};
    assign ifa.pixel_in = display[rd_addr_a];
    assign ifb.pixel_in = 1'b0;

    pix_t exp_q[$];
    int   ev_q[$];
    int   total = 0;
    int   bad   = 0;
    int   plots_a = 0, shifts_a = 0, spawns_a = 0, shifts_b = 0;
    int   viol_a = 0, viol_b = 0;
    int   steps_since_b = 0;
    logic prev_spawn_a = 1'b0, prev_busy_b = 1'b0, prev_ovr_b = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push_scan(input int n);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.x      = 4'((i % 512) / 32);
            p.y      = 5'(i % 32);
            p.colour = ((i % 512) == 167) ? 3'b111 : 3'b000;
            exp_q.push_back(p);
        end
    endtask

    task automatic ev_cmp(input int code);
        int w;
        total++;
        if (ev_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got code %0d want none", code);
        end else begin
            w = ev_q.pop_front();
            if (w != code) begin
                bad++;
                $display("FAIL strobe_order: got code %0d want %0d", code, w);
            end
        end
    endtask

    task automatic wait_drained(input int lim, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > lim && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_in_time"}, int'(exp_q.size() <= lim), 1);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_rd_addr"}, int'({ifa.x_rd, ifa.y_rd}), 0);
        check({tag, "_vga"}, int'({ifa.x, ifa.y, ifa.colour, ifa.plot}), 0);
        check({tag, "_strobes"}, int'({shift_a, spawn_a}), 0);
        check({tag, "_busy_ovr"}, int'({busy_a, ovr_a}), 0);
    endtask

    // monitor: scoreboard pops on every plot and every strobe
    always @(negedge clock) begin
        pix_t got, want;
        if (ifa.plot) begin
            plots_a++;
            got = {ifa.x, ifa.y, ifa.colour};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d want no plot",
                         got.x, got.y, got.colour);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    bad++;
                    $display("FAIL pixel: got x=%0d y=%0d colour=%0d want x=%0d y=%0d colour=%0d",
                             got.x, got.y, got.colour, want.x, want.y, want.colour);
                end
            end
        end
        if (spawn_a) begin
            spawns_a++;
            ev_cmp(EV_SPAWN);
        end
        if (shift_a) begin
            shifts_a++;
            ev_cmp(prev_spawn_a ? EV_SHIFT_AFTER_SPAWN : EV_SHIFT);
        end
        if ((shift_a && busy_a) || (shift_a && spawn_a)) viol_a++;
        prev_spawn_a = spawn_a;

        if (shift_b) begin
            shifts_b++;
            steps_since_b++;
        end
        if ((shift_b && busy_b) || steps_since_b > 1 || (prev_ovr_b && !ovr_b && !reset))
            viol_b++;
        if ((prev_busy_b && !busy_b) || reset) steps_since_b = 0;
        prev_busy_b = busy_b;
        prev_ovr_b  = ovr_b;
    end

    initial begin
        int n;
        int snap_plots, snap_strobes;

        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_a("reset");
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check_idle_a("paused");
        check("paused_activity", plots_a + shifts_a + spawns_a, 0);
        check("paused_b", int'({busy_b, shift_b, spawn_b, ovr_b}), 0);

        // consumed ticks: 1 scan, 2 shift, 3 scan, 4 shift, 5 scan, 6 spawn+shift
        ev_q.push_back(EV_SHIFT);
        ev_q.push_back(EV_SHIFT);
        ev_q.push_back(EV_SPAWN);
        ev_q.push_back(EV_SHIFT_AFTER_SPAWN);
        push_scan(512 * 6);
        run = 1'b1;
        n = 0;
        while (!busy_a && n < 50) begin
            @(negedge clock);
            n++;
        end
        // tick on edge 8 sets pending, IDLE consumes on edge 9, two SETTLE cycles
        check("first_scan_start", n, 11);
        wait_drained(0, 3600, "six_scans");
        check("six_scans_events", ev_q.size(), 0);
        check("shift_count", shifts_a, 3);
        check("spawn_count", spawns_a, 1);
        check("overrun_a", int'(ovr_a), 1);
        check("overrun_b", int'(ovr_b), 1);
        check("b_stepped", int'(shifts_b > 0), 1);

        // scan 7 is a rescan; abort it with reset while y_rd=12 is issued
        push_scan(12);
        n = 0;
        while (!(busy_a && ifa.x_rd == 4'd0 && ifa.y_rd == 5'd12) && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("reach_y12", int'(busy_a && ifa.y_rd == 5'd12), 1);
        reset = 1'b1;
        @(negedge clock);
        check_idle_a("abort");
        check("abort_leftover", exp_q.size(), 0);
        @(negedge clock);
        reset = 1'b0;

        // counters restart: same pattern, spawn on the 3rd step again
        ev_q.push_back(EV_SHIFT);
        ev_q.push_back(EV_SHIFT);
        ev_q.push_back(EV_SPAWN);
        ev_q.push_back(EV_SHIFT_AFTER_SPAWN);
        push_scan(512 * 6);
        wait_drained(512 * 5 - 256, 1200, "mid_scan2");
        run = 1'b0;
        wait_drained(512 * 4, 600, "scan2_done");
        snap_plots   = plots_a;
        snap_strobes = shifts_a + spawns_a;
        repeat (200) @(negedge clock);
        check("pause_plots", plots_a - snap_plots, 0);
        check("pause_strobes", shifts_a + spawns_a - snap_strobes, 0);
        check("pause_busy", int'(busy_a), 0);
        check("pause_events_left", ev_q.size(), 3);
        run = 1'b1;
        wait_drained(10, 2600, "resume");
        run = 1'b0;
        wait_drained(0, 100, "final_scan");
        repeat (20) @(negedge clock);
        check("final_events", ev_q.size(), 0);
        check("final_busy", int'(busy_a), 0);
        check("overrun_a_again", int'(ovr_a), 1);
        check("viol_a", viol_a, 0);
        check("viol_b", viol_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
